// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
// Delay-slot branch behaviour is selected with the CPU_DELAY_SLOT_EN macro.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;
    localparam logic [3:0]  BYTEENABLE_WORD      = 4'b1111;
    localparam logic [31:0] WORD_STEP            = 32'd4;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/cpu_sequencer_pc_unit.sv
// Program counter, next-PC selection and halt/misalignment detection.
// With CPU_DELAY_SLOT_EN defined a taken branch is deferred by one instruction.
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exec_en,
    input  logic        retire,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        next_halt,
    output logic        next_misaligned,
    output logic        pc_misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] exec_next;
    logic [31:0] held_next;

    assign seq_pc = pc + WORD_STEP;

`ifdef CPU_DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_target;

    // A branch seen while a target is already pending sits in a delay slot and is ignored.
    assign exec_next = pend_valid ? pend_target : seq_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
        end else if (exec_en && branch_taken && !pend_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= branch_target;
        end else if (retire && pend_valid) begin
            pend_valid  <= 1'b0;
        end
    end
`else
    assign exec_next = branch_taken ? branch_target : seq_pc;
`endif

    // Branch inputs are only valid in EXEC, so loads and stores retire from this copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_next <= 32'h0;
        end else if (exec_en) begin
            held_next <= exec_next;
        end
    end

    assign next_pc = exec_en ? exec_next : held_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_VECTOR;
        end else if (retire) begin
            pc <= next_pc;
        end
    end

    assign next_halt       = (next_pc == HALT_ADDR);
    assign next_misaligned = !word_aligned(next_pc);
    assign pc_misaligned   = !word_aligned(pc);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute/memory sequencer for the single-cycle MIPS datapath on one
// Avalon-style bus. CPU_DELAY_SLOT_EN selects MIPS branch-delay-slot semantics.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_waitrequest,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] dp_data_address,
    input  logic [31:0] dp_data_writedata,
    output logic [31:0] dp_data_readdata,
    output logic        reg_write_en
);

    state_t      state;
    state_t      state_next;
    logic        mem_is_store;
    logic        retire;
    logic        fault_set;
    logic        exec_en;
    logic        data_misaligned;
    logic [31:0] next_pc;
    logic        next_halt;
    logic        next_misaligned;
    logic        pc_misaligned;

    assign exec_en         = (state == EXEC);
    assign data_misaligned = !word_aligned(dp_data_address);
    assign mem_byteenable  = BYTEENABLE_WORD;
    assign active          = !reset && (state != IDLE) && (state != HALTED);

    pc_unit #(
        .RESET_VECTOR (RESET_VECTOR),
        .HALT_ADDR    (HALT_ADDR)
    ) u_pc_unit (
        .clk             (clk),
        .reset           (reset),
        .exec_en         (exec_en),
        .retire          (retire),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .pc              (pc),
        .next_pc         (next_pc),
        .next_halt       (next_halt),
        .next_misaligned (next_misaligned),
        .pc_misaligned   (pc_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            instr            <= 32'h0;
            dp_data_readdata <= 32'h0;
            fault            <= 1'b0;
            mem_is_store     <= 1'b0;
        end else begin
            state <= state_next;
            if (fault_set) begin
                fault <= 1'b1;
            end
            if (state == FETCH && !mem_waitrequest) begin
                instr <= mem_readdata;
            end
            if (state == EXEC) begin
                mem_is_store <= is_store && !is_load;
            end
            if (state == MEM && !mem_is_store && !mem_waitrequest) begin
                dp_data_readdata <= mem_readdata;
            end
        end
    end

    always_comb begin
        state_next    = state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {pc[31:2], 2'b00};
        mem_writedata = 32'h0;
        reg_write_en  = 1'b0;
        retire        = 1'b0;
        fault_set     = 1'b0;

        case (state)
            IDLE: begin
                if (pc_misaligned) begin
                    fault_set  = 1'b1;
                    state_next = HALTED;
                end else begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (is_load || is_store) begin
                    if (data_misaligned) begin
                        fault_set  = 1'b1;
                        state_next = HALTED;
                    end else begin
                        state_next = MEM;
                    end
                end else begin
                    reg_write_en = 1'b1;
                    retire       = 1'b1;
                end
            end
            MEM: begin
                mem_address = {dp_data_address[31:2], 2'b00};
                if (mem_is_store) begin
                    mem_write     = 1'b1;
                    mem_writedata = dp_data_writedata;
                    if (!mem_waitrequest) begin
                        retire = 1'b1;
                    end
                end else begin
                    mem_read = 1'b1;
                    if (!mem_waitrequest) begin
                        state_next = WB;
                    end
                end
            end
            WB: begin
                reg_write_en = 1'b1;
                retire       = 1'b1;
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The misaligned-fetch check happens here so FETCH is never entered with a bad PC.
        if (retire) begin
            if (next_halt) begin
                state_next = HALTED;
            end else if (next_misaligned) begin
                fault_set  = 1'b1;
                state_next = HALTED;
            end else begin
                state_next = FETCH;
            end
        end

        // Strobes drop in the reset cycle itself, abandoning any outstanding transfer.
        if (reset) begin
            mem_read     = 1'b0;
            mem_write    = 1'b0;
            reg_write_en = 1'b0;
            retire       = 1'b0;
            fault_set    = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a bus slave replays queued transactions
// with per-transaction wait states; a small decoder model drives the control inputs.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    localparam logic [31:0] ADDU = 32'h0043_0821;
    localparam logic [31:0] LW   = 32'h8C41_0000;
    localparam logic [31:0] SW   = 32'hAC41_0004;
    localparam logic [31:0] JR0  = 32'h0000_0008;
    localparam logic [31:0] RV   = 32'hBFC0_0000;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        active;
    logic        fault;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic        mem_waitrequest;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_load;
    logic        is_store;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] dp_data_address;
    logic [31:0] dp_data_writedata;
    logic [31:0] dp_data_readdata;
    logic        reg_write_en;

    logic [31:0] data_addr;
    logic [31:0] rt_value;
    logic [31:0] rs_value;

    txn_t sb_q[$];
    txn_t exp_txn;
    int   stall_left;
    int   total;
    int   bad;

    cpu_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .active            (active),
        .fault             (fault),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_waitrequest   (mem_waitrequest),
        .mem_writedata     (mem_writedata),
        .mem_byteenable    (mem_byteenable),
        .mem_readdata      (mem_readdata),
        .pc                (pc),
        .instr             (instr),
        .is_load           (is_load),
        .is_store          (is_store),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .dp_data_address   (dp_data_address),
        .dp_data_writedata (dp_data_writedata),
        .dp_data_readdata  (dp_data_readdata),
        .reg_write_en      (reg_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder/datapath stand-in
    assign is_load           = (instr[31:26] == 6'h23);
    assign is_store          = (instr[31:26] == 6'h2B);
    assign branch_taken      = (instr[31:26] == 6'h00) && (instr[5:0] == 6'h08);
    assign branch_target     = rs_value;
    assign dp_data_address   = data_addr;
    assign dp_data_writedata = rt_value;

    assign mem_waitrequest = (mem_read || mem_write) && (stall_left != 0);

    // Slave: wait count and read data come from the head of the scoreboard
    always @(posedge clk) begin
        if ((mem_read || mem_write) && mem_waitrequest)
            stall_left <= stall_left - 1;
        else
            stall_left <= (sb_q.size() > 0) ? sb_q[0].stall : 0;
        mem_readdata <= (sb_q.size() > 0 && !sb_q[0].is_write) ? sb_q[0].data : 32'h0;
    end

    // Scoreboard: every accepted transfer must match the head of the queue
    always @(negedge clk) begin
        if (!reset && (mem_read || mem_write)) begin
            total++;
            if (mem_read && mem_write) begin
                bad++;
                $display("[TB] FAIL both_strobes: read=%b write=%b want not both", mem_read, mem_write);
            end
            if (!mem_waitrequest) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_txn: write=%b addr=%h want no transfer", mem_write, mem_address);
                end else begin
                    exp_txn = sb_q.pop_front();
                    if (mem_write !== exp_txn.is_write || mem_address !== exp_txn.addr ||
                        (exp_txn.is_write && mem_writedata !== exp_txn.data) || mem_byteenable !== 4'hF) begin
                        bad++;
                        $display("[TB] FAIL bus_txn: got w=%b a=%h d=%h be=%h want w=%b a=%h d=%h be=f",
                                 mem_write, mem_address, mem_writedata, mem_byteenable,
                                 exp_txn.is_write, exp_txn.addr, exp_txn.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int s);
        txn_t t;
        t.is_write = w;
        t.addr     = a;
        t.data     = d;
        t.stall    = s;
        sb_q.push_back(t);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_reset();
        reset = 1'b1;
        step();
        step();
        sb_q.delete();
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        start_reset();
        total++;
        if (pc !== RV) begin bad++; $display("[TB] FAIL reset_pc: got %h want %h", pc, RV); end
        total++;
        if (instr !== 32'h0 || dp_data_readdata !== 32'h0) begin
            bad++; $display("[TB] FAIL reset_regs: instr=%h rdata=%h want 0 0", instr, dp_data_readdata);
        end
        total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || reg_write_en !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_strobes: r=%b w=%b rwe=%b want 0 0 0", mem_read, mem_write, reg_write_en);
        end
        total++;
        if (active !== 1'b0 || fault !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_flags: active=%b fault=%b want 0 0", active, fault);
        end
        total++;
        if (dut.state !== IDLE) begin bad++; $display("[TB] FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
    endtask

    task automatic test_alu();
        start_reset();
        push_txn(1'b0, RV, ADDU, 0);
        push_txn(1'b0, RV + 32'd4, ADDU, 1000);
        release_reset();
        total++;
        if (mem_read !== 1'b0 || active !== 1'b0) begin
            bad++; $display("[TB] FAIL alu_idle: read=%b active=%b want 0 0", mem_read, active);
        end
        step();
        total++;
        if (mem_read !== 1'b1 || mem_address !== RV || reg_write_en !== 1'b0) begin
            bad++; $display("[TB] FAIL alu_fetch: read=%b addr=%h rwe=%b want 1 %h 0", mem_read, mem_address, reg_write_en, RV);
        end
        step();
        total++;
        if (reg_write_en !== 1'b1 || mem_read !== 1'b0 || instr !== ADDU) begin
            bad++; $display("[TB] FAIL alu_exec: rwe=%b read=%b instr=%h want 1 0 %h", reg_write_en, mem_read, instr, ADDU);
        end
        step();
        total++;
        if (pc !== RV + 32'd4 || mem_read !== 1'b1 || mem_address !== RV + 32'd4) begin
            bad++; $display("[TB] FAIL alu_next: pc=%h read=%b addr=%h want %h 1 %h", pc, mem_read, mem_address, RV + 32'd4, RV + 32'd4);
        end
    endtask

    task automatic test_load();
        int data_cycles = 0;
        int rwe = 0;
        int wr = 0;
        int next_c = -1;
        start_reset();
        data_addr = 32'h0000_1000;
        push_txn(1'b0, RV, LW, 0);
        push_txn(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 3);
        push_txn(1'b0, RV + 32'd4, ADDU, 1000);
        release_reset();
        for (int c = 2; c <= 40; c++) begin
            step();
            if (mem_read && mem_address == 32'h0000_1000) data_cycles++;
            if (mem_write) wr++;
            if (reg_write_en) rwe++;
            if (mem_read && mem_address == RV + 32'd4) begin
                next_c = c;
                break;
            end
        end
        total++;
        if (next_c !== 9) begin bad++; $display("[TB] FAIL load_cycles: next fetch at %0d want 9", next_c); end
        total++;
        if (data_cycles !== 4) begin bad++; $display("[TB] FAIL load_addr_stable: got %0d cycles want 4", data_cycles); end
        total++;
        if (rwe !== 1 || wr !== 0) begin bad++; $display("[TB] FAIL load_rwe: rwe=%0d writes=%0d want 1 0", rwe, wr); end
        total++;
        if (dp_data_readdata !== 32'hDEAD_BEEF) begin
            bad++; $display("[TB] FAIL load_data: got %h want deadbeef", dp_data_readdata);
        end
        total++;
        if (pc !== RV + 32'd4 || fault !== 1'b0) begin
            bad++; $display("[TB] FAIL load_pc: pc=%h fault=%b want %h 0", pc, fault, RV + 32'd4);
        end
    endtask

    task automatic test_store();
        int rwe = 0;
        int wr = 0;
        int next_c = -1;
        start_reset();
        data_addr = 32'h0000_2004;
        rt_value  = 32'h1234_5678;
        push_txn(1'b0, RV, SW, 0);
        push_txn(1'b1, 32'h0000_2004, 32'h1234_5678, 0);
        push_txn(1'b0, RV + 32'd4, ADDU, 1000);
        release_reset();
        for (int c = 2; c <= 40; c++) begin
            step();
            if (reg_write_en) rwe++;
            if (mem_write) begin
                wr++;
                total++;
                if (mem_writedata !== 32'h1234_5678 || mem_byteenable !== 4'hF || mem_address !== 32'h0000_2004) begin
                    bad++; $display("[TB] FAIL store_bus: d=%h be=%h a=%h want 12345678 f 00002004",
                                    mem_writedata, mem_byteenable, mem_address);
                end
            end
            if (mem_read && mem_address == RV + 32'd4) begin
                next_c = c;
                break;
            end
        end
        total++;
        if (next_c !== 5) begin bad++; $display("[TB] FAIL store_cycles: next fetch at %0d want 5", next_c); end
        total++;
        if (rwe !== 0 || wr !== 1) begin bad++; $display("[TB] FAIL store_rwe: rwe=%0d writes=%0d want 0 1", rwe, wr); end
        total++;
        if (pc !== RV + 32'd4) begin bad++; $display("[TB] FAIL store_pc: got %h want %h", pc, RV + 32'd4); end
    endtask

    task automatic test_jump();
        int rwe = 0;
        int fetches = 0;
        int late_strobes = 0;
        int halt_c = -1;
        int exp_rwe;
        int exp_halt_c;
        start_reset();
        rs_value = 32'h0;
        push_txn(1'b0, RV, JR0, 0);
`ifdef CPU_DELAY_SLOT_EN
        push_txn(1'b0, RV + 32'd4, ADDU, 0);
        exp_rwe    = 2;
        exp_halt_c = 6;
`else
        exp_rwe    = 1;
        exp_halt_c = 4;
`endif
        release_reset();
        for (int c = 2; c <= 20; c++) begin
            step();
            if (reg_write_en) rwe++;
            if (mem_read && !mem_waitrequest) fetches++;
            if (halt_c >= 0 && (mem_read || mem_write)) late_strobes++;
            if (halt_c < 0 && !active) halt_c = c;
        end
        total++;
        if (halt_c !== exp_halt_c) begin bad++; $display("[TB] FAIL jump_halt_cycle: got %0d want %0d", halt_c, exp_halt_c); end
        total++;
        if (rwe !== exp_rwe || fetches !== exp_rwe) begin
            bad++; $display("[TB] FAIL jump_count: rwe=%0d fetches=%0d want %0d %0d", rwe, fetches, exp_rwe, exp_rwe);
        end
        total++;
        if (late_strobes !== 0 || active !== 1'b0 || dut.state !== HALTED) begin
            bad++; $display("[TB] FAIL jump_halted: strobes=%0d active=%b state=%0d want 0 0 %0d",
                            late_strobes, active, dut.state, HALTED);
        end
        total++;
        if (pc !== 32'h0 || fault !== 1'b0) begin bad++; $display("[TB] FAIL jump_pc: pc=%h fault=%b want 0 0", pc, fault); end
    endtask

    task automatic test_misaligned();
        int reads = 0;
        int rwe = 0;
        start_reset();
        data_addr = 32'h0000_1002;
        push_txn(1'b0, RV, LW, 0);
        release_reset();
        for (int c = 2; c <= 12; c++) begin
            step();
            if (mem_read || mem_write) reads++;
            if (reg_write_en) rwe++;
        end
        total++;
        if (reads !== 1 || rwe !== 0) begin
            bad++; $display("[TB] FAIL misalign_bus: strobe cycles=%0d rwe=%0d want 1 0", reads, rwe);
        end
        total++;
        if (fault !== 1'b1 || active !== 1'b0 || dut.state !== HALTED) begin
            bad++; $display("[TB] FAIL misalign_fault: fault=%b active=%b state=%0d want 1 0 %0d",
                            fault, active, dut.state, HALTED);
        end
    endtask

    task automatic test_back_to_back();
        int rwe = 0;
        int next_c = -1;
        start_reset();
        data_addr = 32'h0000_3000;
        rt_value  = 32'hCAFE_F00D;
        push_txn(1'b0, RV, ADDU, 1);
        push_txn(1'b0, RV + 32'd4, SW, 0);
        push_txn(1'b1, 32'h0000_3000, 32'hCAFE_F00D, 2);
        push_txn(1'b0, RV + 32'd8, LW, 0);
        push_txn(1'b0, 32'h0000_3000, 32'h0BAD_F00D, 0);
        push_txn(1'b0, RV + 32'd12, ADDU, 1000);
        release_reset();
        for (int c = 2; c <= 60; c++) begin
            step();
            if (reg_write_en) rwe++;
            if (mem_read && mem_address == RV + 32'd12) begin
                next_c = c;
                break;
            end
        end
        total++;
        if (next_c !== 14) begin bad++; $display("[TB] FAIL b2b_cycles: park fetch at %0d want 14", next_c); end
        total++;
        if (rwe !== 2 || dp_data_readdata !== 32'h0BAD_F00D) begin
            bad++; $display("[TB] FAIL b2b_result: rwe=%0d rdata=%h want 2 0badf00d", rwe, dp_data_readdata);
        end
        total++;
        if (pc !== RV + 32'd12 || sb_q.size() !== 1) begin
            bad++; $display("[TB] FAIL b2b_pc: pc=%h pending=%0d want %h 1", pc, sb_q.size(), RV + 32'd12);
        end
    endtask

    task automatic test_reset_mid_fetch();
        start_reset();
        push_txn(1'b0, RV, ADDU, 1000);
        release_reset();
        repeat (4) step();
        total++;
        if (mem_read !== 1'b1 || mem_waitrequest !== 1'b1) begin
            bad++; $display("[TB] FAIL midreset_stall: read=%b wait=%b want 1 1", mem_read, mem_waitrequest);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mem_read !== 1'b0) begin bad++; $display("[TB] FAIL midreset_drop: read=%b want 0", mem_read); end
        step();
        total++;
        if (mem_read !== 1'b0 || pc !== RV || dut.state !== IDLE || fault !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_after: read=%b pc=%h state=%0d fault=%b want 0 %h %0d 0",
                            mem_read, pc, dut.state, fault, RV, IDLE);
        end
        sb_q.delete();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        data_addr = 32'h0;
        rt_value  = 32'h0;
        rs_value  = 32'h0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_jump();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
